// File: rtl/clip_player_pkg.sv
// Shared state encoding and volume constants for the multi-clip PCM player.
package clip_player_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int VOL_W     = 4;
  localparam int VOL_SHIFT = 4;
endpackage

// File: rtl/clip_vol_scale.sv
// Aligns a ROM sample to the output width and scales it by (vol+1)/16.
// One register stage; output is forced to zero whenever the input is not valid.
module clip_vol_scale
  import clip_player_pkg::*;
#(
  parameter int SAMPLE_W = 8,
  parameter int OUT_W    = 16
) (
  input  logic                clk_8000,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] data,
  input  logic [VOL_W-1:0]    vol,
  input  logic                in_valid,
  output logic [OUT_W-1:0]    sample_out,
  output logic                sample_valid
);
  localparam int PW = OUT_W + VOL_W + 1;

  logic signed [PW-1:0] aligned_x;
  logic signed [PW-1:0] gain_x;
  logic signed [PW-1:0] prod;
  logic [OUT_W-1:0]     scaled;
  logic                 unused_bits;
  logic [OUT_W-1:0]     sample_out_q;
  logic                 sample_valid_q;

  assign aligned_x = PW'($signed({data, {(OUT_W-SAMPLE_W){1'b0}}}));
  assign gain_x    = $signed(PW'(vol) + PW'(1));
  assign prod      = aligned_x * gain_x;
  // Taking the slice is the arithmetic shift; the gain of at most 16 keeps it in range.
  assign scaled      = prod[OUT_W+VOL_SHIFT-1:VOL_SHIFT];
  assign unused_bits = ^{prod[PW-1:OUT_W+VOL_SHIFT], prod[VOL_SHIFT-1:0]};

  always_ff @(posedge clk_8000 or posedge rst) begin
    if (rst) begin
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      sample_valid_q <= in_valid;
      sample_out_q   <= in_valid ? scaled : '0;
    end
  end

  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
endmodule

// File: rtl/clip_player.sv
// Multi-clip PCM player: walks a clip's ROM window once or in a loop and streams
// volume-scaled samples, one per clk_8000 cycle; stop/retrigger discard in-flight data.
module clip_player
  import clip_player_pkg::*;
#(
  parameter int ADDR_W    = 17,
  parameter int SAMPLE_W  = 8,
  parameter int OUT_W     = 16,
  parameter int NUM_CLIPS = 4,
  parameter int CLIP_W    = 2,
  parameter int ROM_LAT   = 1
) (
  input  logic                        clk_8000,
  input  logic                        rst,
  input  logic                        trig,
  input  logic [CLIP_W-1:0]           clip_id,
  input  logic                        loop,
  input  logic                        stop,
  input  logic [VOL_W-1:0]            vol,
  input  logic [NUM_CLIPS*ADDR_W-1:0] clip_base,
  input  logic [NUM_CLIPS*ADDR_W-1:0] clip_len,
  output logic [ADDR_W-1:0]           rom_addr,
  output logic                        rom_en,
  input  logic [SAMPLE_W-1:0]         rom_data,
  output logic [OUT_W-1:0]            sample_out,
  output logic                        sample_valid,
  output logic                        busy,
  output logic                        done,
  output logic [CLIP_W-1:0]           cur_clip
);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_e              state_q;
  logic [ADDR_W-1:0]   base_q, len_q, off_q, rom_addr_q;
  logic                loop_q, rom_en_q, rom_last_q, done_q;
  logic [CLIP_W-1:0]   cur_clip_q;
  logic [ROM_LAT-1:0]  vpipe_q, lpipe_q;

  logic [ADDR_W-1:0]   sel_base, sel_len;
  logic                start, kill, last_issue, pipe_empty, scale_vld;

  assign sel_base   = clip_base[int'(clip_id)*ADDR_W +: ADDR_W];
  assign sel_len    = clip_len[int'(clip_id)*ADDR_W +: ADDR_W];
  assign start      = trig && !stop && (sel_len != '0);
  assign kill       = stop || start;
  assign last_issue = (off_q == len_q - ONE);
  assign pipe_empty = !rom_en_q && (vpipe_q == '0);
  // Anything already in flight is dropped on the edge that stops or restarts playback.
  assign scale_vld  = vpipe_q[ROM_LAT-1] && !kill;

  always_ff @(posedge clk_8000 or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      off_q      <= '0;
      loop_q     <= 1'b0;
      cur_clip_q <= '0;
      rom_addr_q <= '0;
      rom_en_q   <= 1'b0;
      rom_last_q <= 1'b0;
      vpipe_q    <= '0;
      lpipe_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      vpipe_q <= ROM_LAT'({vpipe_q, rom_en_q});
      lpipe_q <= ROM_LAT'({lpipe_q, rom_last_q});
      done_q  <= lpipe_q[ROM_LAT-1] && !kill;
      if (stop) begin
        state_q    <= ST_IDLE;
        rom_en_q   <= 1'b0;
        rom_last_q <= 1'b0;
        vpipe_q    <= '0;
        lpipe_q    <= '0;
      end else if (start) begin
        state_q    <= ST_PLAY;
        base_q     <= sel_base;
        len_q      <= sel_len;
        loop_q     <= loop;
        cur_clip_q <= clip_id;
        off_q      <= '0;
        rom_en_q   <= 1'b0;
        rom_last_q <= 1'b0;
        vpipe_q    <= '0;
        lpipe_q    <= '0;
      end else begin
        case (state_q)
          ST_PLAY: begin
            rom_addr_q <= base_q + off_q;
            rom_en_q   <= 1'b1;
            rom_last_q <= last_issue && !loop_q;
            if (!last_issue) begin
              off_q <= off_q + ONE;
            end else if (loop_q) begin
              off_q <= '0;
            end else begin
              state_q <= ST_FLUSH;
            end
          end
          ST_FLUSH: begin
            rom_en_q   <= 1'b0;
            rom_last_q <= 1'b0;
            if (pipe_empty) state_q <= ST_IDLE;
          end
          default: begin
            state_q    <= ST_IDLE;
            rom_en_q   <= 1'b0;
            rom_last_q <= 1'b0;
          end
        endcase
      end
    end
  end

  clip_vol_scale #(
    .SAMPLE_W(SAMPLE_W),
    .OUT_W   (OUT_W)
  ) u_scale (
    .clk_8000    (clk_8000),
    .rst         (rst),
    .data        (rom_data),
    .vol         (vol),
    .in_valid    (scale_vld),
    .sample_out  (sample_out),
    .sample_valid(sample_valid)
  );

  assign rom_addr = rom_addr_q;
  assign rom_en   = rom_en_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign cur_clip = cur_clip_q;
endmodule

// File: tb/tb_clip_player.sv
// Bench for clip_player: one ROM_LAT=1 and one ROM_LAT=3 instance on shared stimulus and ROM contents.
module tb_clip_player;
  localparam int AW = 17;

  logic          clk_8000 = 1'b0;
  logic          rst = 1'b1;
  logic          trig = 1'b0, lp = 1'b0, stop = 1'b0;
  logic [1:0]    clip_id = '0;
  logic [3:0]    vol = 4'd15;
  logic [4*AW-1:0] clip_base = '0, clip_len = '0;

  logic [AW-1:0] rom_addr1, rom_addr3;
  logic          rom_en1, rom_en3, sv1, sv3, busy1, busy3, done1, done3;
  logic [7:0]    rd1, rd3, rd3_p0, rd3_p1;
  logic [15:0]   so1, so3;
  logic [1:0]    cc1, cc3;

  logic [7:0]    rom [0:131071];

  typedef struct packed {logic [15:0] s; logic last;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  logic sb_en = 1'b1;

  typedef struct packed {logic [3:0] vol; logic [3:0][15:0] exp;} vec_t;
  vec_t vecs [4];

  int tests = 0, fails = 0;

  always #5 clk_8000 = ~clk_8000;

  clip_player #(.ROM_LAT(1)) u_dut1 (
    .clk_8000(clk_8000), .rst(rst), .trig(trig), .clip_id(clip_id), .loop(lp), .stop(stop),
    .vol(vol), .clip_base(clip_base), .clip_len(clip_len), .rom_addr(rom_addr1),
    .rom_en(rom_en1), .rom_data(rd1), .sample_out(so1), .sample_valid(sv1), .busy(busy1),
    .done(done1), .cur_clip(cc1));

  clip_player #(.ROM_LAT(3)) u_dut3 (
    .clk_8000(clk_8000), .rst(rst), .trig(trig), .clip_id(clip_id), .loop(lp), .stop(stop),
    .vol(vol), .clip_base(clip_base), .clip_len(clip_len), .rom_addr(rom_addr3),
    .rom_en(rom_en3), .rom_data(rd3), .sample_out(so3), .sample_valid(sv3), .busy(busy3),
    .done(done3), .cur_clip(cc3));

  always @(posedge clk_8000) rd1 <= rom[rom_addr1];
  always @(posedge clk_8000) begin
    rd3_p0 <= rom[rom_addr3];
    rd3_p1 <= rd3_p0;
    rd3    <= rd3_p1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_8000);
    #1;
  endtask

  task automatic pulse_trig(input logic [1:0] cid, input logic l);
    clip_id = cid;
    lp      = l;
    trig    = 1'b1;
    tick();
    trig    = 1'b0;
  endtask

  task automatic set_clip(input int i, input logic [AW-1:0] b, input logic [AW-1:0] l);
    clip_base[i*AW +: AW] = b;
    clip_len[i*AW +: AW]  = l;
  endtask

  task automatic set_vec(input int i, input logic [3:0] v, input logic [15:0] e0,
                         input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3);
    vecs[i].vol    = v;
    vecs[i].exp[0] = e0;
    vecs[i].exp[1] = e1;
    vecs[i].exp[2] = e2;
    vecs[i].exp[3] = e3;
  endtask

  task automatic push_exp(input logic [15:0] s, input logic last);
    exp_t e;
    e.s    = s;
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Scoreboard for the ROM_LAT=1 instance: every valid sample must match the next queued value.
  always @(negedge clk_8000) begin
    if (sb_en && !rst) begin
      if (done1 && !sv1) check("sb_done_without_sample", 32'(done1), 32'(sv1));
      if (sv1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_extra_sample: got %0h, expected no sample", so1);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_sample", 32'(so1), 32'(mon_e.s));
          check("sb_done", 32'(done1), 32'(mon_e.last));
        end
      end
    end
  end

  initial begin
    int first, done_cnt, done_edge, busy_done, idle_edge, bad, ai, si;
    logic [AW-1:0] a3 [4];
    logic [15:0]   s3 [4];
    int loop_addr [8];

    for (int a = 0; a < 131072; a++) rom[a] = 8'(a) ^ 8'h5A;
    rom[100] = 8'h10; rom[101] = 8'hF0; rom[102] = 8'h7F; rom[103] = 8'h80;
    rom[200] = 8'h21; rom[201] = 8'h22; rom[202] = 8'h23;
    rom[300] = 8'h01; rom[301] = 8'h02; rom[302] = 8'hFE; rom[303] = 8'h40; rom[304] = 8'hC0;
    rom[17'h1FFFE] = 8'h11; rom[17'h1FFFF] = 8'h22; rom[0] = 8'h33; rom[1] = 8'h44;
    set_clip(0, 17'd100, 17'd4);
    set_clip(1, 17'd200, 17'd3);
    set_clip(2, 17'd300, 17'd5);
    set_clip(3, 17'h1FFFE, 17'd4);

    set_vec(0, 4'd15, 16'h1000, 16'hF000, 16'h7F00, 16'h8000);
    set_vec(1, 4'd7,  16'h0800, 16'hF800, 16'h3F80, 16'hC000);
    set_vec(2, 4'd0,  16'h0100, 16'hFF00, 16'h07F0, 16'hF800);
    set_vec(3, 4'd3,  16'h0400, 16'hFC00, 16'h1FC0, 16'hE000);
    a3 = '{17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001};
    s3 = '{16'h1100, 16'h2200, 16'h3300, 16'h4400};
    loop_addr = '{200, 201, 202, 200, 201, 202, 200, 201};

    // Reset state
    tick();
    check("rst_rom_addr", 32'(rom_addr1), 0);
    check("rst_rom_en", 32'(rom_en1), 0);
    check("rst_sample_out", 32'(so1), 0);
    check("rst_sample_valid", 32'(sv1), 0);
    check("rst_busy", 32'(busy1), 0);
    check("rst_done", 32'(done1), 0);
    check("rst_cur_clip", 32'(cc1), 0);
    check("rst_busy_l3", 32'(busy3), 0);
    rst = 1'b0;
    tick();

    // One-shot clip 0 at several volumes
    for (int v = 0; v < 4; v++) begin
      vol = vecs[v].vol;
      for (int i = 0; i < 4; i++) push_exp(vecs[v].exp[i], i == 3);
      pulse_trig(2'd0, 1'b0);
      first = 0; done_cnt = 0; done_edge = 0; busy_done = 0; idle_edge = 0;
      for (int n = 1; n <= 16; n++) begin
        tick();
        if (n == 1) begin
          check("os_busy_after_trig", 32'(busy1), 1);
          check("os_first_addr", rom_en1 ? 32'(rom_addr1) : 32'hFFFF_FFFF, 100);
        end
        if (sv1 && first == 0) first = n;
        if (done1) begin
          done_cnt++;
          done_edge = n;
          busy_done = int'(busy1);
        end
        if (!busy1) begin
          idle_edge = n;
          break;
        end
      end
      check("os_first_valid_edge", first, 3);
      check("os_done_count", done_cnt, 1);
      check("os_done_edge", done_edge, 6);
      check("os_busy_with_done", busy_done, 1);
      check("os_idle_edge", idle_edge, 7);
      check("os_queue_drained", exp_q.size(), 0);
      tick(); tick(); tick();
    end

    // Loop mode on clip 1, then stop
    sb_en = 1'b0;
    vol = 4'd15;
    pulse_trig(2'd1, 1'b1);
    done_cnt = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      check("loop_addr", rom_en1 ? 32'(rom_addr1) : 32'hFFFF_FFFF, loop_addr[n]);
      if (done1) done_cnt++;
    end
    for (int n = 0; n < 6; n++) begin
      tick();
      if (done1) done_cnt++;
    end
    check("loop_no_done", done_cnt, 0);
    check("loop_busy", 32'(busy1), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy", 32'(busy1), 0);
    check("stop_valid", 32'(sv1), 0);
    check("stop_sample_zero", 32'(so1), 0);
    check("stop_rom_en", 32'(rom_en1), 0);
    bad = 0;
    for (int n = 0; n < 4; n++) begin
      tick();
      bad = bad | int'(done1) | int'(sv1) | int'(done3);
    end
    check("stop_quiet", bad, 0);
    exp_q.delete();
    sb_en = 1'b1;

    // Retrigger clip 2 in the middle of clip 0
    for (int i = 0; i < 4; i++) push_exp(vecs[0].exp[i], i == 3);
    pulse_trig(2'd0, 1'b0);
    tick(); tick(); tick(); tick();
    @(negedge clk_8000);
    #1;
    exp_q.delete();
    push_exp(16'h0100, 1'b0);
    push_exp(16'h0200, 1'b0);
    push_exp(16'hFE00, 1'b0);
    push_exp(16'h4000, 1'b0);
    push_exp(16'hC000, 1'b1);
    pulse_trig(2'd2, 1'b0);
    check("retrig_valid_dropped", 32'(sv1), 0);
    check("retrig_cur_clip", 32'(cc1), 2);
    check("retrig_no_done", 32'(done1), 0);
    tick();
    check("retrig_addr", rom_en1 ? 32'(rom_addr1) : 32'hFFFF_FFFF, 300);
    done_cnt = 0;
    for (int n = 0; n < 20 && busy1; n++) begin
      tick();
      if (done1) done_cnt++;
    end
    check("retrig_done_count", done_cnt, 1);
    check("retrig_queue_drained", exp_q.size(), 0);
    tick(); tick(); tick();

    // Zero-length clip and trig+stop in the same cycle
    set_clip(3, 17'h1FFFE, 17'd0);
    pulse_trig(2'd3, 1'b0);
    bad = 0;
    for (int n = 0; n < 4; n++) begin
      bad = bad | int'(busy1) | int'(rom_en1) | int'(done1) | int'(sv1) | int'(busy3);
      tick();
    end
    check("len0_ignored", bad, 0);
    clip_id = 2'd0;
    trig = 1'b1;
    stop = 1'b1;
    tick();
    trig = 1'b0;
    stop = 1'b0;
    check("trig_stop_busy", 32'(busy1), 0);
    check("trig_stop_cur_clip", 32'(cc1), 2);
    bad = 0;
    for (int n = 0; n < 3; n++) begin
      tick();
      bad = bad | int'(rom_en1) | int'(sv1) | int'(busy1);
    end
    check("trig_stop_idle", bad, 0);

    // ROM_LAT=3 with address wrap at the top of the ROM
    set_clip(3, 17'h1FFFE, 17'd4);
    for (int i = 0; i < 4; i++) push_exp(s3[i], i == 3);
    pulse_trig(2'd3, 1'b0);
    ai = 0; si = 0; first = 0; done_cnt = 0; done_edge = 0;
    for (int n = 1; n <= 14; n++) begin
      tick();
      if (rom_en3 && ai < 4) begin
        check("l3_addr", 32'(rom_addr3), 32'(a3[ai]));
        ai++;
      end
      if (sv3) begin
        if (first == 0) first = n;
        if (si < 4) check("l3_sample", 32'(so3), 32'(s3[si]));
        si++;
      end
      if (done3) begin
        done_cnt++;
        done_edge = n;
      end
    end
    check("l3_addr_count", ai, 4);
    check("l3_first_valid_edge", first, 5);
    check("l3_sample_count", si, 4);
    check("l3_done_count", done_cnt, 1);
    check("l3_done_edge", done_edge, 8);
    check("l3_cur_clip", 32'(cc3), 3);
    check("l3_idle", 32'(busy3), 0);

    // Asynchronous reset in the middle of playback
    sb_en = 1'b0;
    pulse_trig(2'd0, 1'b0);
    tick(); tick(); tick(); tick();
    check("mid_pre_valid", 32'(sv1), 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_rom_addr", 32'(rom_addr1), 0);
    check("mid_rst_rom_en", 32'(rom_en1), 0);
    check("mid_rst_sample_out", 32'(so1), 0);
    check("mid_rst_valid", 32'(sv1), 0);
    check("mid_rst_busy", 32'(busy1), 0);
    check("mid_rst_done", 32'(done1), 0);
    check("mid_rst_cur_clip", 32'(cc1), 0);
    check("mid_rst_l3_busy", 32'(busy3), 0);
    check("mid_rst_l3_rom_en", 32'(rom_en3), 0);
    check("mid_rst_l3_cur_clip", 32'(cc3), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
